// File: rtl/seg7_pkg.sv
// Shared types, widths and the hex-to-segment table for the 4-digit scan controller.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W      = 4;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  typedef struct packed {
    logic             blank;
    logic [VAL_W-1:0] val;
  } digit_t;

  localparam digit_t DIGIT_RST = '{blank: 1'b1, val: '0};

  // Active-high codes, segment a on bit0 through g on bit6.
  function automatic logic [SEG_W-1:0] hex2seg(input logic [VAL_W-1:0] nib);
    logic [SEG_W-1:0] code;
    code = '0;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register-side write/commit bus and display pin bundle of the scan controller.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
  ();

  logic                  wr_en;
  logic [DIG_W-1:0]      wr_addr;
  digit_t                wr_data;
  logic                  commit;
  logic [NUM_DIGITS-1:0] enable;
  logic [SEG_W-1:0]      segment;
  logic [NUM_DIGITS-1:0] indicator;
  logic                  commit_ack;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, commit, enable,
    input  segment, indicator, commit_ack, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, enable,
    output segment, indicator, commit_ack, frame_tick
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-high 7-segment code.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [VAL_W-1:0] nib,
  output logic [SEG_W-1:0] code_c
);

  assign code_c = hex2seg(nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment driver with double-buffered digit registers
// and blanking gaps between digit slots.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DWELL          = 5000,
  parameter int unsigned BLANK          = 50,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [DIG_W-1:0]      LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_OFF    = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? '1 : '0;

  state_e                state_q, state_d;
  logic [DIG_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pending_q;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                active_q [NUM_DIGITS];
  logic [SEG_W-1:0]      segment_q;
  logic [NUM_DIGITS-1:0] indicator_q;
  logic                  commit_ack_q;
  logic                  frame_tick_q;

  logic                  frame_end_c;
  logic                  copy_c;
  logic                  lit_c;
  digit_t                cur_c;
  logic [SEG_W-1:0]      code_c;
  logic [SEG_W-1:0]      segment_d;
  logic [NUM_DIGITS-1:0] indicator_d;

  // Slot sequencer: SCAN(k) for DWELL cycles, then GAP(k) for BLANK cycles.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q + CNT_W'(1);
    frame_end_c = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == BLANK_LAST) begin
          state_d     = ST_SCAN;
          cnt_d       = '0;
          k_d         = k_q + DIG_W'(1);
          frame_end_c = (k_q == LAST_DIGIT);
        end
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    endcase
  end

  assign copy_c = frame_end_c && (pending_q || bus.commit);

  assign cur_c = active_q[k_q];

  seg7_decode u_decode (
    .nib    (cur_c.val),
    .code_c (code_c)
  );

  // Output levels for the current slot; enable is sampled live.
  always_comb begin
    lit_c       = (state_q == ST_SCAN) && bus.enable[k_q] && !cur_c.blank;
    segment_d   = SEG_OFF;
    indicator_d = DIG_OFF;
    if (lit_c) begin
      segment_d   = code_c ^ SEG_OFF;
      indicator_d = (NUM_DIGITS'(1) << k_q) ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_GAP;
      k_q          <= LAST_DIGIT;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      segment_q    <= SEG_OFF;
      indicator_q  <= DIG_OFF;
      commit_ack_q <= 1'b0;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= DIGIT_RST;
        active_q[i] <= DIGIT_RST;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      segment_q    <= segment_d;
      indicator_q  <= indicator_d;
      frame_tick_q <= frame_end_c;
      commit_ack_q <= copy_c;
      // Copy reads the pre-edge shadow, so a coincident write waits for the next commit.
      if (copy_c) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end else if (bus.commit) begin
        pending_q <= 1'b1;
      end
      if (bus.wr_en) begin
        shadow_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign bus.segment    = segment_q;
  assign bus.indicator  = indicator_q;
  assign bus.commit_ack = commit_ack_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DWELL=4, BLANK=2 and active-high outputs.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .DWELL          (4),
    .BLANK          (2),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk n cycles of one frame starting just after a frame_tick sample.
  // Digit d is lit at offsets 6d+1..6d+4; segs value 0 means that slot stays dark.
  task automatic run_frame(input string tag,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic ack_exp, input int n,
                           input int wr_at, input logic [1:0] wa, input logic [4:0] wd,
                           input int c_a, input int c_b);
    logic [6:0] segs [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_ind;
    int d;
    int ph;
    segs = '{s0, s1, s2, s3};
    for (int j = 1; j <= n; j++) begin
      bus.wr_en   = (j == wr_at);
      bus.wr_addr = wa;
      bus.wr_data = digit_t'(wd);
      bus.commit  = (j == c_a) || (j == c_b);
      step();
      bus.wr_en  = 1'b0;
      bus.commit = 1'b0;
      d  = (j - 1) / 6;
      ph = (j - 1) % 6;
      exp_seg = (ph < 4) ? segs[d] : 7'h00;
      exp_ind = (exp_seg != 7'h00) ? 4'(1 << d) : 4'h0;
      check($sformatf("%s j=%0d seg", tag, j), 32'(bus.segment), 32'(exp_seg));
      check($sformatf("%s j=%0d ind", tag, j), 32'(bus.indicator), 32'(exp_ind));
      check($sformatf("%s j=%0d tick", tag, j), 32'(bus.frame_tick), 32'(j == 24));
      check($sformatf("%s j=%0d ack", tag, j), 32'(bus.commit_ack), 32'((j == 24) && ack_exp));
    end
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit  = 1'b0;
    bus.enable  = 4'hF;

    repeat (3) step();
    check("rst seg", 32'(bus.segment), 32'h00);
    check("rst ind", 32'(bus.indicator), 32'h0);
    check("rst ack", 32'(bus.commit_ack), 32'h0);
    check("rst tick", 32'(bus.frame_tick), 32'h0);

    // Release; write digit 0 in the first gap cycle, then commit on the frame-end cycle.
    @(negedge clk);
    reset_n     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = digit_t'(5'h01);
    step();
    check("rel1 ind", 32'(bus.indicator), 32'h0);
    check("rel1 tick", 32'(bus.frame_tick), 32'h0);
    bus.wr_addr = 2'd1;
    bus.wr_data = digit_t'(5'h02);
    bus.commit  = 1'b1;
    step();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    check("rel2 ind", 32'(bus.indicator), 32'h0);
    check("rel2 tick", 32'(bus.frame_tick), 32'h1);
    check("rel2 ack", 32'(bus.commit_ack), 32'h1);

    // Digit 1 write coincided with the copy, so it stays dark until a later commit.
    run_frame("f1", 7'h06, 7'h00, 7'h00, 7'h00, 1'b0, 24, 3, 2'd2, 5'h03, -1, -1);
    run_frame("f2", 7'h06, 7'h00, 7'h00, 7'h00, 1'b1, 24, 5, 2'd3, 5'h04, 8, -1);
    run_frame("f3", 7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, 24, 2, 2'd0, 5'h08, -1, -1);
    run_frame("f4", 7'h06, 7'h5B, 7'h4F, 7'h66, 1'b1, 24, -1, 2'd0, 5'h00, 10, -1);
    run_frame("f5", 7'h7F, 7'h5B, 7'h4F, 7'h66, 1'b1, 24, 24, 2'd2, 5'h0F, 3, 20);
    run_frame("f6", 7'h7F, 7'h5B, 7'h4F, 7'h66, 1'b1, 24, -1, 2'd0, 5'h00, 5, -1);

    bus.enable = 4'b0101;
    run_frame("f7", 7'h7F, 7'h00, 7'h71, 7'h00, 1'b1, 24, 1, 2'd0, 5'h18, 2, -1);
    run_frame("f8", 7'h00, 7'h00, 7'h71, 7'h00, 1'b0, 24, -1, 2'd0, 5'h00, -1, -1);

    // Leave a commit pending and reset while digit 2 is showing.
    bus.enable = 4'hF;
    run_frame("f9", 7'h00, 7'h5B, 7'h71, 7'h66, 1'b0, 14, -1, 2'd0, 5'h00, 2, -1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid rst seg", 32'(bus.segment), 32'h00);
    check("mid rst ind", 32'(bus.indicator), 32'h0);
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("post rst c%0d ack", i), 32'(bus.commit_ack), 32'h0);
      check($sformatf("post rst c%0d ind", i), 32'(bus.indicator), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
